// File: rtl/config_pkg.sv
// config_pkg: shared definitions for the fabric configuration loader and
// for the tile-side address matchers that decode the config bus.
//   - FSM state enum (ST_CHECK exists only when CONFIG_LOADER_CHECKSUM_EN
//     is defined)
//   - default header tag and idle bus address
//   - header field positions and tile/module address field ranges
//   - small field-extraction helpers
package config_pkg;

    localparam int          WORD_W        = 32;
    localparam int          HOLD_W        = 4;
    localparam logic [7:0]  CFG_MAGIC     = 8'hC5;
    localparam logic [31:0] CFG_IDLE_ADDR = 32'hFFFF_FFFF;

    // Header word layout: tag in the top byte, write count in the low half.
    localparam int HDR_MAGIC_MSB = 31;
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_COUNT_MSB = 15;
    localparam int HDR_COUNT_LSB = 0;

    // Config bus address layout. The tile id 16'hFFFF is reserved so that
    // the idle address is never matched by any tile.
    localparam int          TILE_MSB      = 15;
    localparam int          TILE_LSB      = 0;
    localparam int          MODULE_MSB    = 31;
    localparam int          MODULE_LSB    = 16;
    localparam logic [15:0] TILE_RESERVED = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRIVE = 3'd3,
        ST_GAP   = 3'd4,
`ifdef CONFIG_LOADER_CHECKSUM_EN
        ST_DONE  = 3'd5,
        ST_CHECK = 3'd6
`else
        ST_DONE  = 3'd5
`endif
    } state_t;

    function automatic logic [7:0] hdr_magic(input logic [31:0] w);
        return w[HDR_MAGIC_MSB:HDR_MAGIC_LSB];
    endfunction

    function automatic logic [15:0] hdr_count(input logic [31:0] w);
        return w[HDR_COUNT_MSB:HDR_COUNT_LSB];
    endfunction

    function automatic logic [15:0] tile_id(input logic [31:0] addr);
        return addr[TILE_MSB:TILE_LSB];
    endfunction

    function automatic logic [15:0] module_field(input logic [31:0] addr);
        return addr[MODULE_MSB:MODULE_LSB];
    endfunction

endpackage

// File: rtl/config_loader_if.sv
// config_loader_if: input word stream plus the shared config bus.
//   in_valid/in_word : stream from host (host -> loader)
//   in_ready         : loader accepts in_word this cycle (loader -> host)
//   config_addr/data : config bus into the tile array (loader -> tiles)
// Handshake: a word transfers on every rising edge where in_valid and
// in_ready are both high; the host holds in_word stable while in_valid is
// high and in_ready is low, and in_ready never depends on in_valid.
// Modports: slave = loader side, master = host/observer side.
interface config_loader_if;
    import config_pkg::*;

    logic              in_valid;
    logic [WORD_W-1:0] in_word;
    logic              in_ready;
    logic [WORD_W-1:0] config_addr;
    logic [WORD_W-1:0] config_data;

    modport master (
        output in_valid, in_word,
        input  in_ready, config_addr, config_data
    );

    modport slave (
        input  in_valid, in_word,
        output in_ready, config_addr, config_data
    );

endinterface

// File: rtl/config_hold_timer.sv
// config_hold_timer: 4-bit down-counter timing the DRIVE window.
//   clk, reset (async, active-low)
//   load/load_val : preload the count (window length minus one)
//   en            : count down while the window is open
//   expire        : count has reached zero (last cycle of the window)
module config_hold_timer
    import config_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [HOLD_W-1:0] load_val,
    input  logic              en,
    output logic              expire
);

    logic [HOLD_W-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expire = (count_q == '0);

endmodule

// File: rtl/config_loader.sv
// config_loader: fabric configuration sequencer. Consumes framed records
// (header, then N x {addr, data}) from a valid/ready stream and replays each
// as a write on the shared config bus, held for HOLD_CYCLES (1..15) cycles
// and followed by one idle-address cycle.
//   clk, reset (async, active-low)
//   cfg       : stream input and config bus (config_loader_if.slave)
//   err_clr   : clears the sticky error flag (a same-cycle error wins)
//   busy      : frame in progress
//   done      : one-cycle pulse at frame end
//   err       : sticky error (bad header tag, or checksum mismatch)
//   writes    : writes issued in the current or last frame
//   state_dbg : current FSM state
// Optional feature macro CONFIG_LOADER_CHECKSUM_EN: each frame with N > 0
// carries a trailing word equal to the XOR of its header and all addr/data
// words, checked in the CHECK state.
module config_loader
    import config_pkg::*;
#(
    parameter int          HOLD_CYCLES = 2,
    parameter logic [31:0] IDLE_ADDR   = CFG_IDLE_ADDR,
    parameter logic [7:0]  MAGIC       = CFG_MAGIC
) (
    input  logic           clk,
    input  logic           reset,
    config_loader_if.slave cfg,
    input  logic           err_clr,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [15:0]    writes,
    output state_t         state_dbg
);

    // The timer counts down to zero, so it is preloaded with one less than
    // the window length.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] writes_q, writes_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] bus_addr_q, bus_data_q;
    logic        busy_q, done_q, err_q, err_d;
    logic        set_err, ready;
    logic        timer_load, timer_en, timer_expire;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    config_hold_timer u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (HOLD_LOAD),
        .en       (timer_en),
        .expire   (timer_expire)
    );

    assign timer_en = (state_q == ST_DRIVE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        writes_d   = writes_q;
        addr_d     = addr_q;
        data_d     = data_q;
        set_err    = 1'b0;
        timer_load = 1'b0;
        ready      = 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (cfg.in_valid) begin
                    if (hdr_magic(cfg.in_word) == MAGIC) begin
                        count_d  = hdr_count(cfg.in_word);
                        writes_d = '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        csum_d   = cfg.in_word;
`endif
                        state_d  = (hdr_count(cfg.in_word) == 16'd0) ? ST_DONE : ST_ADDR;
                    end else begin
                        // Drop the word and keep hunting for a good header.
                        set_err = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                ready = 1'b1;
                if (cfg.in_valid) begin
                    addr_d  = cfg.in_word;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ cfg.in_word;
`endif
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                ready = 1'b1;
                if (cfg.in_valid) begin
                    data_d     = cfg.in_word;
                    timer_load = 1'b1;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ cfg.in_word;
`endif
                    state_d    = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (timer_expire) begin
                    writes_d = writes_q + 16'd1;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (writes_q == count_q) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_ADDR;
                end
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                ready = 1'b1;
                if (cfg.in_valid) begin
                    if (cfg.in_word != csum_q) begin
                        set_err = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new error in the same cycle as err_clr leaves the flag set.
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (set_err) begin
            err_d = 1'b1;
        end
    end

    // Outputs are registered from the next state so the bus changes on the
    // same edge the FSM enters or leaves DRIVE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            writes_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            bus_addr_q <= IDLE_ADDR;
            bus_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            writes_q   <= writes_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            bus_addr_q <= (state_d == ST_DRIVE) ? addr_d : IDLE_ADDR;
            bus_data_q <= (state_d == ST_DRIVE) ? data_d : 32'd0;
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
            err_q      <= err_d;
        end
    end

`ifdef CONFIG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign cfg.in_ready    = ready;
    assign cfg.config_addr = bus_addr_q;
    assign cfg.config_data = bus_data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err             = err_q;
    assign writes          = writes_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: self-checking bench for config_loader. A cycle-indexed
// reference model derives every expected output from the frame timing
// rules; directed frames add literal expectations.
// Honours CONFIG_LOADER_CHECKSUM_EN in the same way as the design.
module tb_config_loader;
    import config_pkg::*;

    localparam int          H    = 2;
    localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
    localparam logic [7:0]  MG   = 8'hC5;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        err_clr = 1'b0;
    logic        busy, done, err;
    logic [15:0] writes;
    state_t      state_dbg;

    config_loader_if cfg();

    config_loader #(.HOLD_CYCLES(H), .IDLE_ADDR(IDLE), .MAGIC(MG)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg       (cfg),
        .err_clr   (err_clr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .writes    (writes),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish in time (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // Expectations are kept as cycle numbers: a data accepted in cycle t is
    // on the bus for t+1..t+H, counted at t+H+1, and so on.
    bit          mon_en = 1'b0;
    int          phase;          // 0 header, 1 addr, 2 data, 3 checksum
    int          m_n, m_done, m_writes;
    bit          m_err, m_err_nxt;
    logic [31:0] m_csum, drv_addr, drv_data;
    longint      block_until, done_at, busy_start, busy_end;
    longint      drv_lo, drv_hi, inc_at, clr_at;
    int          drive_seen;
    logic [31:0] last_addr, last_data;

    task automatic model_reset();
        phase = 0; m_n = 0; m_done = 0; m_writes = 0;
        m_err = 1'b0; m_err_nxt = 1'b0; m_csum = '0;
        drv_addr = '0; drv_data = '0;
        block_until = -1; done_at = -1; busy_start = 1; busy_end = 0;
        drv_lo = 1; drv_hi = 0; inc_at = -1; clr_at = -1;
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] w;
        bit          in_drv, e_ready, hs;
        if (mon_en) begin
            if (cyc == clr_at) m_writes = 0;
            if (cyc == inc_at) m_writes = m_writes + 1;
            m_err   = m_err_nxt;
            in_drv  = (cyc >= drv_lo) && (cyc <= drv_hi);
            e_ready = (cyc > block_until);

            check("in_ready",    cfg.in_ready, e_ready);
            check("config_addr", cfg.config_addr, in_drv ? drv_addr : IDLE);
            check("config_data", cfg.config_data, in_drv ? drv_data : 32'd0);
            check("busy",        busy, (cyc >= busy_start) && (cyc <= busy_end));
            check("done",        done, cyc == done_at);
            check("err",         err, m_err);
            check("writes",      writes, m_writes);

            if (cfg.config_addr !== IDLE || cfg.config_data !== 32'd0) begin
                drive_seen++;
                last_addr = cfg.config_addr;
                last_data = cfg.config_data;
            end

            m_err_nxt = m_err;
            if (err_clr) m_err_nxt = 1'b0;
            hs = cfg.in_valid && e_ready;
            w  = cfg.in_word;
            if (hs) begin
                case (phase)
                    0: begin
                        if (w[31:24] == MG) begin
                            m_n = int'(w[15:0]); m_done = 0; m_csum = w;
                            clr_at = cyc + 1; busy_start = cyc + 1; busy_end = 64'h7FFF_FFFF_FFFF;
                            if (m_n == 0) begin
                                done_at = cyc + 1; busy_end = cyc + 1; block_until = cyc + 1;
                            end else begin
                                phase = 1;
                            end
                        end else begin
                            m_err_nxt = 1'b1;
                        end
                    end
                    1: begin
                        drv_addr = w; m_csum = m_csum ^ w; phase = 2;
                    end
                    2: begin
                        drv_data = w; m_csum = m_csum ^ w; m_done++;
                        drv_lo = cyc + 1; drv_hi = cyc + H; inc_at = cyc + H + 1;
                        if (m_done < m_n) begin
                            block_until = cyc + H + 1; phase = 1;
                        end else if (CSUM_ON) begin
                            block_until = cyc + H + 1; phase = 3;
                        end else begin
                            block_until = cyc + H + 2; done_at = cyc + H + 2;
                            busy_end = cyc + H + 2; phase = 0;
                        end
                    end
                    default: begin
                        if (w != m_csum) m_err_nxt = 1'b1;
                        done_at = cyc + 1; busy_end = cyc + 1; block_until = cyc + 1;
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // ---------------- driver tasks ----------------
    bit          clr_rand = 1'b0;
    logic [31:0] frm_a[16];
    logic [31:0] frm_d[16];

    task automatic sync();
        @(posedge clk);
        #1;
        err_clr = clr_rand && ($urandom_range(0, 7) == 0);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        bit got = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin
            cfg.in_valid = 1'b0; cfg.in_word = $urandom; sync();
        end
        cfg.in_valid = 1'b1; cfg.in_word = w;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (cfg.in_ready) got = 1'b1;
        end
        sync();
        cfg.in_valid = 1'b0; cfg.in_word = $urandom;
        check("handshake_timeout", got, 1'b1);
    endtask

    task automatic send_frame(input logic [31:0] hdr, input bit corrupt, input int max_gap);
        logic [31:0] cs;
        cs = hdr;
        send_word(hdr, max_gap);
        for (int i = 0; i < int'(hdr[15:0]); i++) begin
            send_word(frm_a[i], max_gap); cs = cs ^ frm_a[i];
            send_word(frm_d[i], max_gap); cs = cs ^ frm_d[i];
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        if (hdr[15:0] != 16'd0) begin
            if (corrupt) cs = cs ^ 32'h0000_0100;
            send_word(cs, max_gap);
        end
`else
        if (corrupt) cs = '0;
`endif
    endtask

    // Leaves the caller at the negedge where done is seen.
    task automatic wait_done();
        bit got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("done_timeout", got, 1'b1);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("rst_addr",   cfg.config_addr, IDLE);
        check("rst_data",   cfg.config_data, 32'd0);
        check("rst_ready",  cfg.in_ready, 1'b1);
        check("rst_busy",   busy, 1'b0);
        check("rst_done",   done, 1'b0);
        check("rst_err",    err, 1'b0);
        check("rst_writes", writes, 16'd0);
        check("rst_state",  state_dbg, ST_IDLE);
        cfg.in_valid = 1'b0;
        err_clr      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        mon_en = 1'b1;
        sync();
    endtask

    task automatic frame_one();
        drive_seen = 0;
        frm_a[0] = 32'h0001_0003; frm_d[0] = 32'h0000_0005;
        send_frame(32'hC500_0001, 1'b0, 0);
        wait_done();
        check("f1_writes", writes, 16'd1);
        check("f1_drive_cycles", drive_seen, 2);
        check("f1_addr", last_addr, 32'h0001_0003);
        check("f1_data", last_data, 32'h0000_0005);
        check("f1_err", err, 1'b0);
        sync();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] bad, hdr;
        int          n;
        cfg.in_valid = 1'b0;
        cfg.in_word  = '0;
        #1;
        do_reset();

        frame_one();

        // Empty frame: done one cycle after the header, bus stays idle.
        drive_seen = 0;
        send_frame(32'hC500_0000, 1'b0, 0);
        wait_done();
        check("n0_drive_cycles", drive_seen, 0);
        check("n0_writes", writes, 16'd0);
        sync();

        // Bad tag, then a good frame; then clear the flag.
        send_word(32'hAA00_0002, 0);
        frm_a[0] = 32'h0002_0010; frm_d[0] = 32'hDEAD_BEEF;
        send_frame(32'hC500_0001, 1'b0, 0);
        wait_done();
        check("bad_hdr_err", err, 1'b1);
        check("bad_hdr_writes", writes, 16'd1);
        sync();
        err_clr = 1'b1;
        sync();
        @(negedge clk);
        check("err_after_clr", err, 1'b0);
        sync();

        // Three writes with a stalling source.
        drive_seen = 0;
        for (int i = 0; i < 3; i++) begin
            frm_a[i] = 32'h0003_0001 + i; frm_d[i] = 32'h1000_0000 + i;
        end
        send_frame(32'hC500_0003, 1'b0, 3);
        wait_done();
        check("n3_drive_cycles", drive_seen, 6);
        check("n3_writes", writes, 16'd3);
        check("n3_last_addr", last_addr, 32'h0003_0003);
        sync();

`ifdef CONFIG_LOADER_CHECKSUM_EN
        frm_a[0] = 32'h0004_0001; frm_d[0] = 32'h0000_00AA;
        send_frame(32'hC500_0001, 1'b0, 1);
        wait_done();
        check("csum_good_err", err, 1'b0);
        sync();
        send_frame(32'hC500_0001, 1'b1, 1);
        wait_done();
        check("csum_bad_err", err, 1'b1);
        sync();
        err_clr = 1'b1;
        sync();
`endif

        // Randomised frames, junk words and err_clr pulses.
        clr_rand = 1'b1;
        for (int f = 0; f < 14; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                bad = $urandom;
                if (bad[31:24] == MG) bad[31:24] = ~MG;
                send_word(bad, 2);
            end
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) begin
                frm_a[i] = ($urandom_range(0, 7) == 0) ? IDLE : $urandom;
                frm_d[i] = $urandom;
            end
            hdr = {MG, 8'($urandom), 16'(n)};
            send_frame(hdr, $urandom_range(0, 2) == 0, 2);
            wait_done();
            sync();
        end
        clr_rand = 1'b0;
        sync();

        // Reset in the middle of a DRIVE window.
        send_word(32'hC500_0002, 0);
        send_word(32'h0005_0007, 0);
        send_word(32'h0000_0077, 0);
        check("pre_reset_addr", cfg.config_addr, 32'h0005_0007);
        #2;
        do_reset();

        frame_one();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
